// File: rtl/store_narrow.sv
// -----------------------------------------------------------------------------
// store_narrow
//
// Store-side narrowing and buffering between the MEM stage and data memory.
// A 32-bit register value is cut down to a byte, halfword or word. The kept
// bits are replicated across the byte lanes, and byte enables select the
// lanes that memory actually writes. A 2-entry circular FIFO absorbs memory
// back-pressure. Misaligned or reserved-size requests are consumed but are
// not written. Each one raises a one-cycle err pulse and records its address.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   st_valid   store request present
//   st_ready   unit can accept a request (registered, independent of mem_ready)
//   st_addr    byte address of the store
//   st_data    register value to store
//   st_size    00 word, 01 halfword, 10 byte, 11 reserved
//   mem_valid  head entry valid toward memory
//   mem_ready  memory accepts the head entry this cycle
//   mem_addr   word-aligned address of the head entry
//   mem_wdata  lane-steered write data of the head entry
//   mem_be     byte enables of the head entry (bit i -> bits 8i+7:8i)
//   err        one-cycle pulse after an illegal request is consumed
//   err_addr   st_addr of the most recent illegal request
//   empty      FIFO holds no entries
// -----------------------------------------------------------------------------
module store_narrow #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        err,
    output logic [31:0] err_addr,
    output logic        empty
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } entry_t;

    entry_t      fifo_mem [DEPTH];
    entry_t      head;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    logic        legal;
    logic [31:0] narrow_wdata;
    logic [3:0]  narrow_be;
    logic        accept;
    logic        push;
    logic        pop;

    // Size decode, alignment check and lane steering of the incoming request.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise a latch is inferred.
    always_comb begin
        legal        = 1'b0;
        narrow_wdata = '0;
        narrow_be    = '0;
        case (st_size)
            2'b00: begin
                legal        = (st_addr[1:0] == 2'b00);
                narrow_wdata = st_data;
                narrow_be    = 4'b1111;
            end
            2'b01: begin
                legal        = ~st_addr[0];
                narrow_wdata = {2{st_data[15:0]}};
                narrow_be    = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                legal        = 1'b1;
                narrow_wdata = {4{st_data[7:0]}};
                narrow_be    = 4'b0001 << st_addr[1:0];
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    assign st_ready  = (count != FULL);
    assign mem_valid = (count != 2'd0);
    assign empty     = (count == 2'd0);

    assign accept = st_valid && st_ready;
    assign push   = accept && legal;
    assign pop    = mem_valid && mem_ready;

    // Head outputs are forced to zero while empty, so stale storage is never
    // presented. This also covers the period during and after reset.
    assign head      = fifo_mem[rd_ptr];
    assign mem_addr  = mem_valid ? head.addr  : '0;
    assign mem_wdata = mem_valid ? head.wdata : '0;
    assign mem_be    = mem_valid ? head.be    : '0;

    // Pointers and occupancy. With two entries each pointer is one bit, so
    // wrapping modulo 2 is a toggle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset. Its contents are dead whenever
    // count is zero, and the output gating above keeps them off the port.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr:  {st_addr[31:2], 2'b00},
                                  wdata: narrow_wdata,
                                  be:    narrow_be};
        end
    end

    // Error reporting. err pulses for each consumed illegal request, so
    // back-to-back illegal requests produce back-to-back pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            err <= accept && !legal;
            if (accept && !legal) err_addr <= st_addr;
        end
    end

endmodule
